// File: rtl/d1fifo_reader.sv
// -----------------------------------------------------------------------------
// d1fifo_reader
//
// Pop-side reader for the d1 single-port FIFO family. Issues fifo_pop against
// the FIFO empty flag, absorbs the fixed FIFO read latency (RD_LAT cycles from
// pop to fifo_valid), and re-presents the returned words as a valid/ready
// stream out of a small circular buffer. Also sequences a FIFO flush and drops
// the stale returns still in flight when the flush was taken.
//
// Ports:
//   clk         clock, single domain
//   rst         synchronous active-high reset
//   flush       request to flush the FIFO and the reader
//   fifo_empty  FIFO empty flag (combinational from FIFO pointers)
//   fifo_rdata  FIFO read data, qualified by fifo_valid
//   fifo_valid  FIFO read-return strobe
//   fifo_pop    pop request to the FIFO
//   fifo_flush  flush to the FIFO
//   m_data      stream data (head of the output buffer)
//   m_valid     stream valid
//   m_ready     stream ready
//   busy        high while words are in flight or buffered, or while draining
//   err         (only with D1FIFO_READER_ERR_EN) sticky return-protocol error
//
// Optional feature macro: D1FIFO_READER_ERR_EN
//   Adds the err port and checks every read return against the in-flight
//   record; unexpected returns are not written to the buffer.
// -----------------------------------------------------------------------------
module d1fifo_reader #(
   parameter int WIDTH  = 16,
   parameter int RD_LAT = 2,
   parameter int DEPTH  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   input  logic             fifo_valid,
   output logic             fifo_pop,
   output logic             fifo_flush,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy
`ifdef D1FIFO_READER_ERR_EN
   ,
   output logic             err
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(RD_LAT + 1);
   localparam int OW = $clog2(DEPTH + RD_LAT + 1);
   localparam int DW = $clog2(RD_LAT + 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [RD_LAT-1:0] inflight_q, inflight_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic [NW-1:0]     n_inflight;
   logic [OW-1:0]     occupancy;
   logic              pop;
   logic              wr_en;
   logic              rd_en;

`ifdef D1FIFO_READER_ERR_EN
   logic              err_q, err_d;
`endif

   // Circular pointer advance; DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      drain_d  = drain_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      n_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         n_inflight = n_inflight + NW'(inflight_q[i]);
      end

      // Credit check counts buffered plus in-flight words only; crediting a
      // same-cycle dequeue would put m_ready on the pop timing path.
      occupancy = OW'(count_q) + OW'(n_inflight);
      pop = !rst && (state_q == RUN) && !flush && !fifo_empty &&
            (occupancy < OW'(DEPTH));

      rd_en = (count_q != '0) && m_ready;
`ifdef D1FIFO_READER_ERR_EN
      // Only returns matched by the oldest in-flight pop are accepted.
      wr_en = (state_q == RUN) && fifo_valid && inflight_q[RD_LAT-1];
      err_d = err_q | ((state_q == RUN) && (fifo_valid != inflight_q[RD_LAT-1]));
`else
      wr_en = (state_q == RUN) && fifo_valid;
`endif

      // bit RD_LAT-1 marks the pop whose return is due this cycle
      inflight_d[0] = pop;
      for (int i = 1; i < RD_LAT; i++) begin
         inflight_d[i] = inflight_q[i-1];
      end

      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         RUN: begin
            if (flush) begin
               // Everything buffered or in flight is discarded at this edge.
               state_d    = DRAIN;
               drain_d    = DW'(RD_LAT);
               count_d    = '0;
               rd_ptr_d   = '0;
               wr_ptr_d   = '0;
               inflight_d = '0;
            end
         end
         DRAIN: begin
            // Returns for pops issued before the flush arrive during these
            // RD_LAT cycles and are ignored because wr_en requires RUN.
            if (flush) begin
               drain_d = DW'(RD_LAT);
            end else begin
               drain_d = drain_q - DW'(1);
               if (drain_q == DW'(1)) state_d = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= RUN;
         drain_q    <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         // NOTE: the storage is reset because m_data reads the head entry
         // directly and must be 0 out of reset; at DEPTH entries this is cheap.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef D1FIFO_READER_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (wr_en) mem_q[wr_ptr_q] <= fifo_rdata;
`ifdef D1FIFO_READER_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   assign fifo_pop   = pop;
   assign fifo_flush = !rst && flush;
   assign m_valid    = (count_q != '0);
   assign m_data     = mem_q[rd_ptr_q];
   assign busy       = (count_q != '0) || (n_inflight != '0) || (state_q == DRAIN);
`ifdef D1FIFO_READER_ERR_EN
   assign err        = err_q;
`endif

endmodule

// File: tb/tb_d1fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_d1fifo_reader
//
// Drives d1fifo_reader from a behavioural FIFO (a queue plus an RD_LAT-deep
// return pipeline). Every word the DUT pops is pushed onto an expected queue;
// a flush or reset empties that queue, since all popped-but-undelivered words
// are discarded. A negedge monitor pops and compares on each m_valid&&m_ready
// and checks pop gating, busy, flush forwarding and stall stability from the
// queue sizes and a drain-cycle countdown.
// -----------------------------------------------------------------------------
module tb_d1fifo_reader;

   localparam int WIDTH  = 16;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             fifo_empty = 1'b1;
   logic [WIDTH-1:0] fifo_rdata = '0;
   logic             fifo_valid = 1'b0;
   logic             m_ready = 1'b0;
   logic             fifo_pop;
   logic             fifo_flush;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             busy;
`ifdef D1FIFO_READER_ERR_EN
   logic             err;
`endif

   d1fifo_reader #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_valid (fifo_valid),
      .fifo_pop   (fifo_pop),
      .fifo_flush (fifo_flush),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy)
`ifdef D1FIFO_READER_ERR_EN
      ,
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [WIDTH-1:0] fifo_q [$];   // words stored in the behavioural FIFO
   logic [WIDTH-1:0] exp_q [$];    // popped words not yet delivered
   logic             pipe_v [RD_LAT];
   logic [WIDTH-1:0] pipe_d [RD_LAT];
   int               drain_left = 0;
   bit               cleared = 1'b0;
   bit               cleared_rst = 1'b0;

   bit               s_rst = 1'b0, s_flush = 1'b0, s_pop = 1'b0, s_fflush = 1'b0;
   bit               prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   int               first_pop = -1;
   int               beat_q [$];
   logic [WIDTH-1:0] beat_d [$];

   logic [WIDTH-1:0] next_word = '0;
   bit               rand_data = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples mid-cycle, compares, and pops the scoreboard.
   always @(negedge clk) begin : monitor
      logic [WIDTH-1:0] w;
      bit               pop_exp;
      bit               busy_exp;
      cyc++;
      s_rst    = rst;
      s_flush  = flush;
      s_pop    = fifo_pop;
      s_fflush = fifo_flush;
      check("fifo_flush", {31'd0, fifo_flush}, {31'd0, flush && !rst});
      if (rst) begin
         check("pop_in_reset", {31'd0, fifo_pop}, 32'd0);
      end else begin
         pop_exp  = !flush && (drain_left == 0) && !fifo_empty && (exp_q.size() < DEPTH);
         busy_exp = (exp_q.size() != 0) || (drain_left != 0);
         check("fifo_pop", {31'd0, fifo_pop}, {31'd0, pop_exp});
         check("busy", {31'd0, busy}, {31'd0, busy_exp});
         if (cleared) check("m_valid_after_clear", {31'd0, m_valid}, 32'd0);
         if (cleared_rst) check("m_data_after_reset", {16'd0, m_data}, 32'd0);
         if (prev_stall) begin
            check("stall_valid", {31'd0, m_valid}, 32'd1);
            check("stall_data", {16'd0, m_data}, {16'd0, prev_data});
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("beats_pending", exp_q.size(), 32'd1);
            end else begin
               w = exp_q.pop_front();
               check("m_data", {16'd0, m_data}, {16'd0, w});
               beat_q.push_back(cyc);
               beat_d.push_back(m_data);
            end
         end
      end
`ifdef D1FIFO_READER_ERR_EN
      check("err", {31'd0, err}, 32'd0);
`endif
      prev_stall = !rst && !flush && m_valid && !m_ready;
      prev_data  = m_data;
      if (!rst && fifo_pop && first_pop < 0) first_pop = cyc;
   end

   // Behavioural FIFO and scoreboard producer, acting just after each edge on
   // what the monitor sampled during the cycle that edge closed.
   always begin : model
      @(posedge clk);
      #1;
      if (s_rst) begin
         exp_q.delete();
         for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
         drain_left  = 0;
         cleared     = 1'b1;
         cleared_rst = 1'b1;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
         end
         pipe_v[0] = 1'b0;
         pipe_d[0] = WIDTH'($urandom);
         if (s_pop && fifo_q.size() > 0) begin
            pipe_v[0] = 1'b1;
            pipe_d[0] = fifo_q.pop_front();
            if (!s_flush) exp_q.push_back(pipe_d[0]);
         end
         if (s_fflush) fifo_q.delete();
         cleared_rst = 1'b0;
         if (s_flush) begin
            exp_q.delete();
            drain_left = RD_LAT;
            cleared    = 1'b1;
         end else begin
            cleared = 1'b0;
            if (drain_left > 0) drain_left--;
         end
      end
      fifo_valid = pipe_v[RD_LAT-1];
      fifo_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : WIDTH'($urandom);
   end

   // One clock of stimulus: push words into the FIFO and set the inputs.
   task automatic tick(input bit rdy, input bit fl, input bit rs, input int npush);
      @(posedge clk);
      #2;
      for (int i = 0; i < npush; i++) begin
         fifo_q.push_back(rand_data ? WIDTH'($urandom) : next_word);
         next_word = next_word + 1'b1;
      end
      m_ready    = rdy;
      flush      = fl;
      rst        = rs;
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic clear_beats();
      beat_q.delete();
      beat_d.delete();
   endtask

   initial begin : stimulus
      bit r_rdy, r_fl, r_rs;
      int r_np;
      for (int i = 0; i < RD_LAT; i++) begin
         pipe_v[i] = 1'b0;
         pipe_d[i] = '0;
      end

      // Steady stream: 0x0001..0x0010 preloaded under reset, m_ready high.
      next_word = 16'h0001;
      tick(1, 0, 1, 16);
      tick(1, 0, 1, 0);
      clear_beats();
      first_pop = -1;
      repeat (40) tick(1, 0, 0, 0);
      check("steady_beats", beat_q.size(), 32'd16);
      if (beat_q.size() == 16) begin
         check("first_latency", beat_q[0] - first_pop, RD_LAT + 1);
         check("steady_first", {16'd0, beat_d[0]}, 32'h0001);
         check("steady_last", {16'd0, beat_d[15]}, 32'h0010);
      end

      // Backpressure: m_ready low for cycles 5-12.
      clear_beats();
      next_word = 16'h0101;
      tick(1, 0, 0, 16);
      for (int i = 1; i <= 40; i++) tick(!(i >= 5 && i <= 12), 0, 0, 0);
      check("bp_beats", beat_q.size(), 32'd16);
      if (beat_q.size() == 16) check("bp_last", {16'd0, beat_d[15]}, 32'h0110);

      // Empty gating: 20 empty cycles, then a single word.
      clear_beats();
      repeat (20) tick(1, 0, 0, 0);
      check("empty_no_beats", beat_q.size(), 32'd0);
      next_word = 16'hABCD;
      tick(1, 0, 0, 1);
      repeat (10) tick(1, 0, 0, 0);
      check("empty_one_beat", beat_q.size(), 32'd1);
      if (beat_q.size() == 1) check("empty_word", {16'd0, beat_d[0]}, 32'hABCD);

      // Flush with one word buffered and two in flight.
      clear_beats();
      next_word = 16'h0200;
      tick(0, 0, 0, 5);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      repeat (12) tick(1, 0, 0, 0);
      check("flush_discard", beat_q.size(), 32'd0);
      next_word = 16'h0210;
      tick(1, 0, 0, 4);
      repeat (12) tick(1, 0, 0, 0);
      check("post_flush_beats", beat_q.size(), 32'd4);
      if (beat_q.size() == 4) check("post_flush_first", {16'd0, beat_d[0]}, 32'h0210);

      // Reset mid-stream with two words buffered; FIFO keeps its five.
      clear_beats();
      next_word = 16'h0300;
      tick(0, 0, 0, 8);
      repeat (3) tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      repeat (25) tick(1, 0, 0, 0);
      check("reset_resume_beats", beat_q.size(), 32'd5);
      if (beat_q.size() == 5) check("reset_resume_first", {16'd0, beat_d[0]}, 32'h0303);

      // Randomized traffic with backpressure, flushes and resets.
      rand_data = 1'b1;
      repeat (3000) begin
         r_rdy = ($urandom_range(0, 3) != 0);
         r_fl  = ($urandom_range(0, 63) == 0);
         r_rs  = !r_fl && ($urandom_range(0, 199) == 0);
         r_np  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         tick(r_rdy, r_fl, r_rs, r_np);
      end

      repeat (40) tick(1, 0, 0, 0);
      check("final_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
